pll_rst_seq: RTL
================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter ARST_CYC, default 10, gives the number of cycles pll_areset is held high per PLL reset attempt.
REQ-002 Parameter LOCK_STABLE_CYC, default 1000, gives the number of consecutive synchronized-locked cycles required before releasing the domains.
REQ-003 Parameter N_DOM, default 3, gives the number of downstream reset domains.
REQ-004 Parameter STAGE_GAP, default 16, gives the cycles between successive domain releases.
REQ-005 Parameter TIMEOUT_CYC, default 50000, gives the WAIT_LOCK timeout; it applies only with the macro.
REQ-006 Parameter MAX_RETRY, default 3, gives the timed-out attempts allowed before FAIL; it applies only with the macro.
REQ-007 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-008 Port: sys_clk  input  1  system clock; all logic rises on its posedge.
REQ-009 Port: sys_rst  input  1  asynchronous active-high reset.
REQ-010 Port: pll_locked  input  1  PLL lock flag, asynchronous to sys_clk.
REQ-011 Port: pll_areset  output  1  active-high PLL reset.
REQ-012 Port: dom_rst  output  N_DOM  active-high domain resets; bit 0 is released first.
REQ-013 Port: seq_done  output  1  high while all domains are released and the PLL is locked.
REQ-014 Port: lock_lost_cnt  output  8  count of loss-of-lock events, saturating at 255.
REQ-015 Port: seq_err  output  1  sticky timeout failure flag.

Function
REQ-016 pll_locked SHALL pass through a 2-FF synchronizer to give locked_s, a 2-cycle latency.
REQ-017 The FSM states SHALL be RST_PLL, WAIT_LOCK, RELEASE, RUN and FAIL.
REQ-018 RST_PLL SHALL drive pll_areset=1 and all dom_rst=1 for exactly ARST_CYC cycles, then go to WAIT_LOCK.
REQ-019 WAIT_LOCK SHALL count consecutive cycles with locked_s=1; locked_s=0 SHALL clear the count; when the count reaches LOCK_STABLE_CYC the FSM SHALL go to RELEASE.
REQ-020 RELEASE SHALL clear dom_rst[i] at i*STAGE_GAP cycles after entry (bit 0 on the entry cycle); after clearing bit N_DOM-1 it SHALL go to RUN.
REQ-021 RUN SHALL drive seq_done=1.
REQ-022 In RELEASE or RUN, locked_s=0 SHALL, on the same edge, set all dom_rst=1 and seq_done=0, increment lock_lost_cnt (saturating), and go to RST_PLL.
REQ-023 The counter widths SHALL be $clog2 of the largest applicable parameter plus 1; no counter SHALL wrap.
REQ-024 If a loss of lock and a stage-release boundary coincide, the loss of lock SHALL take priority and no further bit SHALL be released.
REQ-025 Outside RST_PLL, pll_areset SHALL be 0.

Reset
REQ-026 Asserting sys_rst at any time, including mid-RELEASE, SHALL asynchronously force state=RST_PLL, pll_areset=1, dom_rst=all 1, seq_done=0, seq_err=0, lock_lost_cnt=0, all counters=0, and both synchronizer FFs=0.
REQ-027 After sys_rst deasserts, the full ARST_CYC pulse SHALL be produced.

Configuration
REQ-028 The macro PLL_LOCK_TIMEOUT_EN SHALL control the timeout and retry feature.
REQ-029 With PLL_LOCK_TIMEOUT_EN defined, WAIT_LOCK exceeding TIMEOUT_CYC total cycles SHALL increment a retry counter and re-enter RST_PLL.
REQ-030 With PLL_LOCK_TIMEOUT_EN defined, reaching MAX_RETRY timeouts SHALL enter FAIL: seq_err=1, pll_areset=0, dom_rst all 1, exit only by sys_rst.
REQ-031 With PLL_LOCK_TIMEOUT_EN defined, the retry counter SHALL clear on entering RUN.
REQ-032 Without PLL_LOCK_TIMEOUT_EN, WAIT_LOCK SHALL wait indefinitely, FAIL SHALL be unreachable, seq_err SHALL be tied to 0, and no timeout or retry counters SHALL exist.

Structure
REQ-033 Package pll_rst_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-034 The synchronizer SHALL be sub-module sync_2ff (1-bit, reset to 0).
REQ-035 All remaining logic SHALL be in pll_rst_seq.

Verification
REQ-036 Normal bring-up: release sys_rst; pll_locked rises at cycle 30 and stays high -> pll_areset high for 10 cycles; dom_rst 3'b111 -> 3'b110 -> 3'b100 -> 3'b000 at 16-cycle spacing; then seq_done=1.
REQ-037 Glitchy lock: pll_locked drops for 1 cycle at stable-count 500 -> count restarts; release begins 1000 cycles after the last rising edge plus 2 cycles of sync latency.
REQ-038 Loss in RUN: pll_locked falls -> 2 cycles later dom_rst=3'b111, seq_done=0, lock_lost_cnt=1, pll_areset pulses for 10 cycles, and the sequence repeats on relock.
REQ-039 Loss mid-RELEASE: pll_locked falls with dom_rst=3'b110 -> dom_rst returns to 3'b111 and bit 1 is never released.
REQ-040 Timeout (PLL_LOCK_TIMEOUT_EN): pll_locked held at 0 -> 3 pll_areset pulses spaced 50000+10 cycles apart, then seq_err=1 and pll_areset=0; asserting sys_rst clears seq_err.
REQ-041 Saturation: 300 loss events -> lock_lost_cnt=255.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// Shared state encoding and default parameter values for the PLL reset sequencer.
// The optional lock timeout / retry logic is enabled by defining PLL_LOCK_TIMEOUT_EN.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int DEF_ARST_CYC        = 10;
  localparam int DEF_LOCK_STABLE_CYC = 1000;
  localparam int DEF_N_DOM           = 3;
  localparam int DEF_STAGE_GAP       = 16;
  localparam int DEF_TIMEOUT_CYC     = 50000;
  localparam int DEF_MAX_RETRY       = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the system clock domain.
// Both flops clear on the asynchronous reset so the flag reads as unlocked until proven otherwise.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// downstream reset domains one by one. Define PLL_LOCK_TIMEOUT_EN for lock timeout and retry.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int ARST_CYC        = DEF_ARST_CYC,
  parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
  parameter int N_DOM           = DEF_N_DOM,
  parameter int STAGE_GAP       = DEF_STAGE_GAP,
  parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pll_locked,
  output logic             pll_areset,
  output logic [N_DOM-1:0] dom_rst,
  output logic             seq_done,
  output logic [7:0]       lock_lost_cnt,
  output logic             seq_err
);

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int CNT_MAX = max_of(max_of(ARST_CYC, LOCK_STABLE_CYC),
                                  max_of(STAGE_GAP, TIMEOUT_CYC));
  localparam int RTY_W   = $clog2(MAX_RETRY) + 1;
`else
  localparam int CNT_MAX = max_of(max_of(ARST_CYC, LOCK_STABLE_CYC), STAGE_GAP);
`endif
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int STG_W   = $clog2(N_DOM) + 1;

  state_t             state, state_n;
  logic               locked_s;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [STG_W-1:0]   stage, stage_n;
  logic [N_DOM-1:0]   dom_rst_n;
  logic [7:0]         lost_n;
`ifdef PLL_LOCK_TIMEOUT_EN
  logic [CNT_W-1:0]   to_cnt, to_n;
  logic [RTY_W-1:0]   retry, retry_n;
`endif

  sync_2ff u_lock_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= RST_PLL;
      cnt           <= '0;
      stage         <= '0;
      dom_rst       <= '1;
      lock_lost_cnt <= '0;
`ifdef PLL_LOCK_TIMEOUT_EN
      to_cnt        <= '0;
      retry         <= '0;
`endif
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      stage         <= stage_n;
      dom_rst       <= dom_rst_n;
      lock_lost_cnt <= lost_n;
`ifdef PLL_LOCK_TIMEOUT_EN
      to_cnt        <= to_n;
      retry         <= retry_n;
`endif
    end
  end

  // One shared counter serves the reset pulse, the lock-stability run and the stage gap,
  // since only one of them is ever active in a given state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stage_n   = stage;
    dom_rst_n = dom_rst;
    lost_n    = lock_lost_cnt;
`ifdef PLL_LOCK_TIMEOUT_EN
    to_n      = to_cnt;
    retry_n   = retry;
`endif

    unique case (state)
      RST_PLL: begin
        dom_rst_n = '1;
        stage_n   = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
        to_n      = '0;
`endif
        if (cnt == CNT_W'(ARST_CYC - 1)) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (!locked_s) begin
          cnt_n = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
          state_n      = RELEASE;
          cnt_n        = '0;
          stage_n      = STG_W'(1);
          dom_rst_n[0] = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        // A lock that completes on the timeout cycle wins over the timeout.
        if (state_n == WAIT_LOCK) begin
          if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            cnt_n   = '0;
            to_n    = '0;
            retry_n = retry + 1'b1;
            state_n = (retry_n == RTY_W'(MAX_RETRY)) ? FAIL : RST_PLL;
          end else begin
            to_n = to_cnt + 1'b1;
          end
        end
`endif
      end

      RELEASE: begin
        if (!locked_s) begin
          state_n   = RST_PLL;
          cnt_n     = '0;
          stage_n   = '0;
          dom_rst_n = '1;
          if (lock_lost_cnt != 8'hFF) lost_n = lock_lost_cnt + 8'd1;
        end else if (stage >= STG_W'(N_DOM)) begin
          state_n = RUN;
`ifdef PLL_LOCK_TIMEOUT_EN
          retry_n = '0;
`endif
        end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
          cnt_n   = '0;
          stage_n = stage + 1'b1;
          for (int i = 0; i < N_DOM; i++) begin
            if (stage == STG_W'(i)) dom_rst_n[i] = 1'b0;
          end
          if (stage == STG_W'(N_DOM - 1)) begin
            state_n = RUN;
`ifdef PLL_LOCK_TIMEOUT_EN
            retry_n = '0;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RUN: begin
        if (!locked_s) begin
          state_n   = RST_PLL;
          cnt_n     = '0;
          stage_n   = '0;
          dom_rst_n = '1;
          if (lock_lost_cnt != 8'hFF) lost_n = lock_lost_cnt + 8'd1;
        end
      end

      FAIL: begin
        dom_rst_n = '1;
      end

      default: begin
        state_n   = RST_PLL;
        cnt_n     = '0;
        dom_rst_n = '1;
      end
    endcase
  end

  assign pll_areset = (state == RST_PLL);
  assign seq_done   = (state == RUN);
`ifdef PLL_LOCK_TIMEOUT_EN
  assign seq_err    = (state == FAIL);
`else
  assign seq_err    = 1'b0;
`endif

endmodule
